// File: rtl/beep_arbiter_if.sv
// Request/response bundle between the requesters and the buzzer arbiter.
// master drives requests and counts; slave returns the buzzer drive and burst status.
interface beep_arbiter_if;
  logic [2:0] req;
  logic [3:0] req_cnt0;
  logic [3:0] req_cnt1;
  logic [3:0] req_cnt2;
  logic       beep;
  logic [2:0] grant;
  logic       busy;
  logic [2:0] done;

  modport master (
    output req, req_cnt0, req_cnt1, req_cnt2,
    input  beep, grant, busy, done
  );

  modport slave (
    input  req, req_cnt0, req_cnt1, req_cnt2,
    output beep, grant, busy, done
  );
endinterface

// File: rtl/beep_arbiter.sv
// Fixed-priority buzzer arbiter: latches N-beep requests, beep rises one edge after the pend latch when idle.
// No backpressure: requests are always accepted into a per-channel pending slot; no preemption of a running burst.
module beep_arbiter #(
  parameter int unsigned      CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_ON  = 25'd12_499_999,
  parameter logic [CNT_W-1:0] CNT_OFF = 25'd12_499_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  beep_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [CNT_W-1:0] TIMER_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       rem_q, rem_d;
  logic [2:0]       pend_q, pend_d, pend_clr, req_set;
  logic [3:0]       cnt_q [3];
  logic [3:0]       cnt_d [3];
  logic [3:0]       req_cnt [3];
  logic [2:0]       sel_oh;
  logic [3:0]       sel_cnt;
  logic             beep_q, beep_d;
  logic             busy_q, busy_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       done_q, done_d;

  assign req_cnt[0] = bus.req_cnt0;
  assign req_cnt[1] = bus.req_cnt1;
  assign req_cnt[2] = bus.req_cnt2;

  // A new request on the grant edge re-arms the slot after the grant consumed the old count.
  always_comb begin
    req_set = '0;
    for (int i = 0; i < 3; i++) begin
      req_set[i] = bus.req[i] && (req_cnt[i] != 4'd0);
      cnt_d[i]   = req_set[i] ? req_cnt[i] : cnt_q[i];
    end
    pend_d = (pend_q & ~pend_clr) | req_set;
  end

  always_comb begin
    sel_oh  = '0;
    sel_cnt = '0;
    if (pend_q[2]) begin
      sel_oh  = 3'b100;
      sel_cnt = cnt_q[2];
    end else if (pend_q[1]) begin
      sel_oh  = 3'b010;
      sel_cnt = cnt_q[1];
    end else if (pend_q[0]) begin
      sel_oh  = 3'b001;
      sel_cnt = cnt_q[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rem_d    = rem_q;
    beep_d   = beep_q;
    busy_d   = busy_q;
    grant_d  = grant_q;
    done_d   = '0;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != 3'b000) begin
          state_d  = ON;
          beep_d   = 1'b1;
          busy_d   = 1'b1;
          grant_d  = sel_oh;
          rem_d    = sel_cnt;
          timer_d  = '0;
          pend_clr = sel_oh;
        end
      end
      ON: begin
        if (timer_q == CNT_ON) begin
          state_d = OFF;
          beep_d  = 1'b0;
          timer_d = '0;
          rem_d   = rem_q - 4'd1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      OFF: begin
        if (timer_q == CNT_OFF) begin
          timer_d = '0;
          if (rem_q != 4'd0) begin
            state_d = ON;
            beep_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            grant_d = '0;
            done_d  = grant_q;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        beep_d  = 1'b0;
        busy_d  = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      pend_q  <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      beep_q  <= beep_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.beep  = beep_q;
  assign bus.busy  = busy_q;
  assign bus.grant = grant_q;
  assign bus.done  = done_q;

endmodule
